// File: rtl/audio_feed_timer_mc_if.sv
// Avalon-MM control-bus bundle for the multi-channel audio feed timer.
// Address is {channel, reg[2:0]}, sized from the channel count.
interface audio_feed_timer_mc_if #(
   parameter int NUM_CH = 4
) ();
   localparam int ADDR_W = $clog2(NUM_CH) + 3;

   logic [ADDR_W-1:0] address;
   logic              chipselect;
   logic              write_n;
   logic [31:0]       writedata;
   logic [31:0]       readdata;

   modport master (
      output address,
      output chipselect,
      output write_n,
      output writedata,
      input  readdata
   );

   modport slave (
      input  address,
      input  chipselect,
      input  write_n,
      input  writedata,
      output readdata
   );
endinterface

// File: rtl/audio_feed_timer_mc.sv
// NUM_CH independent prescaled down-counters with one-shot/continuous mode,
// overrun flag, tick strobes and per-channel interrupts on an Avalon-MM slave.
module audio_feed_timer_mc #(
   parameter int NUM_CH         = 4,
   parameter int CNT_W          = 32,
   parameter int PRE_W          = 8,
   parameter int DEFAULT_PERIOD = 99999
) (
   input  logic                 clk,
   input  logic                 reset,
   audio_feed_timer_mc_if.slave bus,
   output logic                 irq,
   output logic [NUM_CH-1:0]    irq_vec,
   output logic [NUM_CH-1:0]    tick
);

   localparam logic [CNT_W-1:0] DEF_PERIOD = CNT_W'(DEFAULT_PERIOD);

   localparam logic [2:0] REG_STATUS   = 3'd0;
   localparam logic [2:0] REG_CONTROL  = 3'd1;
   localparam logic [2:0] REG_PERIOD   = 3'd2;
   localparam logic [2:0] REG_SNAPSHOT = 3'd3;
   localparam logic [2:0] REG_PRESCALE = 3'd4;

   logic [CNT_W-1:0] cnt_q    [NUM_CH];
   logic [CNT_W-1:0] cnt_d    [NUM_CH];
   logic [CNT_W-1:0] period_q [NUM_CH];
   logic [CNT_W-1:0] period_d [NUM_CH];
   logic [CNT_W-1:0] snap_q   [NUM_CH];
   logic [CNT_W-1:0] snap_d   [NUM_CH];
   logic [PRE_W-1:0] pre_q    [NUM_CH];
   logic [PRE_W-1:0] pre_d    [NUM_CH];
   logic [PRE_W-1:0] pcnt_q   [NUM_CH];
   logic [PRE_W-1:0] pcnt_d   [NUM_CH];

   logic [NUM_CH-1:0] run_q, run_d;
   logic [NUM_CH-1:0] to_q, to_d;
   logic [NUM_CH-1:0] ovf_q, ovf_d;
   logic [NUM_CH-1:0] ito_q, ito_d;
   logic [NUM_CH-1:0] cont_q, cont_d;
   logic [NUM_CH-1:0] tick_q, tick_d;
   logic [31:0]       readdata_q, readdata_d;

   logic [3:0]        ch_idx;
   logic [2:0]        reg_idx;
   logic              wr_en;
   logic [NUM_CH-1:0] ch_wr;
   logic [NUM_CH-1:0] period_wr;
   logic [NUM_CH-1:0] step;
   logic [NUM_CH-1:0] evt;

   always_comb begin
      reg_idx = bus.address[2:0];
      ch_idx  = 4'(bus.address >> 3);
      wr_en   = bus.chipselect && !bus.write_n;
      for (int c = 0; c < NUM_CH; c++) begin
         ch_wr[c]     = wr_en && (int'(ch_idx) == c);
         period_wr[c] = ch_wr[c] && (reg_idx == REG_PERIOD);
         step[c]      = run_q[c] && (pcnt_q[c] == '0);
         // A PERIOD write on a step edge swallows that step entirely.
         evt[c]       = step[c] && (cnt_q[c] == '0) && !period_wr[c];
      end
   end

   always_comb begin
      cnt_d    = cnt_q;
      period_d = period_q;
      snap_d   = snap_q;
      pre_d    = pre_q;
      pcnt_d   = pcnt_q;
      run_d    = run_q;
      to_d     = to_q;
      ovf_d    = ovf_q;
      ito_d    = ito_q;
      cont_d   = cont_q;
      tick_d   = '0;

      for (int c = 0; c < NUM_CH; c++) begin
         if (run_q[c]) begin
            pcnt_d[c] = step[c] ? pre_q[c] : pcnt_q[c] - PRE_W'(1);
         end

         if (step[c] && !period_wr[c]) begin
            if (evt[c]) begin
               cnt_d[c]  = period_q[c];
               tick_d[c] = 1'b1;
               if (!cont_q[c]) begin
                  run_d[c] = 1'b0;
               end
            end else begin
               cnt_d[c] = cnt_q[c] - CNT_W'(1);
            end
         end

         if (ch_wr[c]) begin
            case (reg_idx)
               REG_STATUS: begin
                  to_d[c]  = 1'b0;
                  ovf_d[c] = 1'b0;
               end
               REG_CONTROL: begin
                  ito_d[c]  = bus.writedata[0];
                  cont_d[c] = bus.writedata[1];
                  if (bus.writedata[3]) begin
                     run_d[c] = 1'b0;
                  end else if (bus.writedata[2]) begin
                     run_d[c]  = 1'b1;
                     pcnt_d[c] = pre_q[c];
                  end
               end
               REG_PERIOD: begin
                  period_d[c] = bus.writedata[CNT_W-1:0];
                  cnt_d[c]    = bus.writedata[CNT_W-1:0];
                  pcnt_d[c]   = pre_q[c];
                  run_d[c]    = 1'b0;
               end
               REG_SNAPSHOT: begin
                  snap_d[c] = cnt_q[c];
               end
               REG_PRESCALE: begin
                  pre_d[c]  = bus.writedata[PRE_W-1:0];
                  pcnt_d[c] = bus.writedata[PRE_W-1:0];
               end
               default: begin
               end
            endcase
         end

         // Applied after the STATUS clear so a coincident timeout is never lost.
         if (evt[c]) begin
            to_d[c]  = 1'b1;
            ovf_d[c] = ovf_d[c] | to_q[c];
         end
      end
   end

   always_comb begin
      readdata_d = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         if (int'(ch_idx) == c) begin
            case (reg_idx)
               REG_STATUS:   readdata_d = {29'd0, ovf_q[c], run_q[c], to_q[c]};
               REG_CONTROL:  readdata_d = {30'd0, cont_q[c], ito_q[c]};
               REG_PERIOD:   readdata_d = 32'(period_q[c]);
               REG_SNAPSHOT: readdata_d = 32'(snap_q[c]);
               REG_PRESCALE: readdata_d = 32'(pre_q[c]);
               default:      readdata_d = '0;
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int c = 0; c < NUM_CH; c++) begin
            cnt_q[c]    <= DEF_PERIOD;
            period_q[c] <= DEF_PERIOD;
            snap_q[c]   <= '0;
            pre_q[c]    <= '0;
            pcnt_q[c]   <= '0;
         end
         run_q      <= '0;
         to_q       <= '0;
         ovf_q      <= '0;
         ito_q      <= '0;
         cont_q     <= '0;
         tick_q     <= '0;
         readdata_q <= '0;
      end else begin
         cnt_q      <= cnt_d;
         period_q   <= period_d;
         snap_q     <= snap_d;
         pre_q      <= pre_d;
         pcnt_q     <= pcnt_d;
         run_q      <= run_d;
         to_q       <= to_d;
         ovf_q      <= ovf_d;
         ito_q      <= ito_d;
         cont_q     <= cont_d;
         tick_q     <= tick_d;
         readdata_q <= readdata_d;
      end
   end

   assign bus.readdata = readdata_q;
   assign irq_vec      = to_q & ito_q;
   assign irq          = |irq_vec;
   assign tick         = tick_q;

endmodule

// File: tb/tb_audio_feed_timer_mc.sv
// Scoreboard bench for audio_feed_timer_mc: directed register traffic pushes
// expected reads/irq samples and tick edges; monitors pop and compare.
module tb_audio_feed_timer_mc;

   localparam int NUM_CH = 4;
   localparam int ADDR_W = $clog2(NUM_CH) + 3;

   typedef struct {
      string       name;
      int          kind;
      logic [31:0] exp;
   } probe_t;

   typedef struct {
      int          edge_n;
      logic [3:0]  vec;
   } tick_exp_t;

   logic              clk = 1'b0;
   logic              reset;
   logic              irq;
   logic [NUM_CH-1:0] irq_vec;
   logic [NUM_CH-1:0] tick;

   int   cycle = 0;
   int   checks = 0;
   int   failures = 0;
   logic sample_req = 1'b0;
   logic sample_vld = 1'b0;

   probe_t    probe_q[$];
   tick_exp_t tick_q[$];

   audio_feed_timer_mc_if #(.NUM_CH(NUM_CH)) bus ();

   audio_feed_timer_mc #(
      .NUM_CH(NUM_CH),
      .CNT_W(32),
      .PRE_W(8),
      .DEFAULT_PERIOD(99999)
   ) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus),
      .irq(irq),
      .irq_vec(irq_vec),
      .tick(tick)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      cycle      <= cycle + 1;
      sample_vld <= sample_req;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cycle);
      end
   endtask

   // Probe monitor: readdata/irq are valid the cycle after the request.
   always @(negedge clk) begin
      probe_t p;
      if (sample_vld) begin
         if (probe_q.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL probe_underflow: got sample expected none");
         end else begin
            p = probe_q.pop_front();
            if (p.kind == 0) check(p.name, bus.readdata, p.exp);
            else             check(p.name, {27'd0, irq_vec, irq}, p.exp);
         end
      end
   end

   // Tick monitor: every strobe must match the next expected edge exactly.
   always @(negedge clk) begin
      tick_exp_t t;
      if (cycle > 0) begin
         while (tick_q.size() > 0 && tick_q[0].edge_n < cycle) begin
            t = tick_q.pop_front();
            check("tick_missing", 32'(t.edge_n), 32'hFFFF_FFFF);
         end
         if (tick !== '0) begin
            if (tick_q.size() == 0) begin
               check("tick_unexpected", {28'd0, tick}, 32'd0);
            end else begin
               t = tick_q.pop_front();
               check("tick_edge", 32'(cycle), 32'(t.edge_n));
               check("tick_vec", {28'd0, tick}, {28'd0, t.vec});
            end
         end
      end
   end

   task automatic push_tick(input int edge_n, input logic [3:0] vec);
      tick_exp_t t;
      t.edge_n = edge_n;
      t.vec    = vec;
      tick_q.push_back(t);
   endtask

   task automatic apply_write(input int ch, input int r, input logic [31:0] d);
      bus.address    = ADDR_W'(ch * 8 + r);
      bus.chipselect = 1'b1;
      bus.write_n    = 1'b0;
      bus.writedata  = d;
      @(negedge clk);
      bus.chipselect = 1'b0;
      bus.write_n    = 1'b1;
   endtask

   task automatic apply_read(input int ch, input int r, input logic [31:0] exp, input string name);
      probe_t p;
      p.name = name;
      p.kind = 0;
      p.exp  = exp;
      probe_q.push_back(p);
      bus.address    = ADDR_W'(ch * 8 + r);
      bus.chipselect = 1'b1;
      bus.write_n    = 1'b1;
      sample_req     = 1'b1;
      @(negedge clk);
      bus.chipselect = 1'b0;
      sample_req     = 1'b0;
   endtask

   task automatic probe_irq(input logic [31:0] exp, input string name);
      probe_t p;
      p.name = name;
      p.kind = 1;
      p.exp  = exp;
      probe_q.push_back(p);
      sample_req = 1'b1;
      @(negedge clk);
      sample_req = 1'b0;
   endtask

   task automatic wait_until(input int target);
      if (cycle > target) begin
         failures++;
         $display("[TB] FAIL schedule: at cycle %0d expected at most %0d", cycle, target);
      end
      while (cycle < target) @(negedge clk);
   endtask

   initial begin
      #300000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int s, s1, s2, s3, r0;
      reset          = 1'b1;
      bus.address    = '0;
      bus.chipselect = 1'b0;
      bus.write_n    = 1'b1;
      bus.writedata  = '0;
      repeat (3) @(negedge clk);
      reset = 1'b0;

      // Reset values
      apply_read(0, 0, 32'd0, "rst_status0");
      apply_read(0, 2, 32'd99999, "rst_period0");
      apply_read(2, 4, 32'd0, "rst_prescale2");
      apply_read(1, 1, 32'd0, "rst_control1");
      probe_irq(32'd0, "rst_irq");

      // Ch0 continuous, PERIOD=3 PRESCALE=2: event every 12 clocks
      apply_write(0, 2, 32'd3);
      apply_write(0, 4, 32'd2);
      s = cycle + 1;
      apply_write(0, 1, 32'h7);
      push_tick(s + 12, 4'b0001);
      push_tick(s + 24, 4'b0001);
      apply_read(0, 1, 32'h3, "ch0_control");
      wait_until(s + 10);
      probe_irq(32'd0, "ch0_irq_before");
      probe_irq(32'h3, "ch0_irq_after");
      apply_read(0, 0, 32'h3, "ch0_status_to");
      apply_write(0, 0, 32'd0);
      probe_irq(32'd0, "ch0_irq_cleared");
      wait_until(s + 23);
      apply_write(0, 0, 32'd0);
      apply_read(0, 0, 32'h3, "ch0_status_evt_wr");
      probe_irq(32'h3, "ch0_irq_held");
      apply_write(0, 1, 32'h8);
      apply_write(0, 0, 32'd0);

      // Ch1 one-shot, PERIOD=5 PRESCALE=0
      apply_write(1, 2, 32'd5);
      apply_write(1, 4, 32'd0);
      s1 = cycle + 1;
      apply_write(1, 1, 32'h4);
      push_tick(s1 + 6, 4'b0010);
      wait_until(s1 + 8);
      apply_read(1, 0, 32'h1, "ch1_status_oneshot");
      apply_write(1, 3, 32'd0);
      apply_read(1, 3, 32'd5, "ch1_counter_reload");
      probe_irq(32'd0, "ch1_no_irq");
      wait_until(s1 + 30);

      // Ch2 continuous, PERIOD=1: overrun after two uncleared events
      apply_write(2, 2, 32'd1);
      apply_write(2, 4, 32'd0);
      s2 = cycle + 1;
      apply_write(2, 1, 32'h6);
      push_tick(s2 + 2, 4'b0100);
      push_tick(s2 + 4, 4'b0100);
      push_tick(s2 + 6, 4'b0100);
      push_tick(s2 + 8, 4'b0100);
      wait_until(s2 + 4);
      apply_read(2, 0, 32'h7, "ch2_status_ovf");
      wait_until(s2 + 6);
      apply_write(2, 0, 32'd0);
      apply_read(2, 0, 32'h2, "ch2_status_cleared");
      apply_write(2, 1, 32'h8);

      // Ch0 PERIOD write mid-run stops the channel
      apply_write(0, 2, 32'd20);
      s3 = cycle + 1;
      apply_write(0, 1, 32'h6);
      apply_read(0, 1, 32'h2, "ch0_control_cont");
      wait_until(s3 + 5);
      apply_write(0, 2, 32'd10);
      apply_write(0, 3, 32'd0);
      apply_read(0, 3, 32'd10, "ch0_snapshot_period");
      apply_read(0, 0, 32'd0, "ch0_status_stopped");
      apply_write(0, 1, 32'hC);
      apply_read(0, 0, 32'd0, "ch0_start_stop");
      apply_read(0, 1, 32'd0, "ch0_control_cleared");
      apply_read(0, 2, 32'd10, "ch0_period10");
      apply_read(0, 5, 32'd0, "ch0_reg5");
      apply_read(0, 7, 32'd0, "ch0_reg7");
      apply_read(3, 7, 32'd0, "ch3_reg7");
      wait_until(s3 + 70);

      // Reset mid-count
      apply_write(3, 4, 32'd5);
      apply_write(3, 1, 32'h7);
      apply_write(0, 4, 32'd0);
      r0 = cycle + 1;
      apply_write(0, 1, 32'h5);
      wait_until(r0 + 4);
      reset = 1'b1;
      apply_read(0, 2, 32'd0, "reset_readdata");
      reset = 1'b0;
      apply_read(0, 2, 32'd99999, "rst2_period0");
      apply_read(0, 0, 32'd0, "rst2_status0");
      apply_read(3, 4, 32'd0, "rst2_prescale3");
      apply_read(3, 1, 32'd0, "rst2_control3");
      probe_irq(32'd0, "rst2_irq");
      apply_write(0, 3, 32'd0);
      apply_read(0, 3, 32'd99999, "rst2_counter0");
      wait_until(r0 + 40);

      repeat (3) @(negedge clk);
      check("tick_queue_drained", 32'(tick_q.size()), 32'd0);
      check("probe_queue_drained", 32'(probe_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
